// File: rtl/fp8_pkg.sv
// Shared definitions for the 8-bit minifloat datapath (adder and converters).
// Format: sign[7] | exponent[6:3] (bias 7) | mantissa[2:0] (hidden 1, no denormals).
// Exponent 15 is reserved for inf (mantissa 0) and NaN (mantissa != 0).
// exp 0 with mant 0 is the adder's zero encoding.
package fp8_pkg;

  localparam int unsigned EXP_W       = 4;
  localparam int unsigned MANT_W      = 3;
  localparam int unsigned FP8_BIAS    = 7;
  localparam int unsigned EXP_SPECIAL = 15;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFix,
    StDone
  } conv_state_e;

  function automatic logic is_nan(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
    return (e == EXP_W'(EXP_SPECIAL)) && (m != '0);
  endfunction

  function automatic logic is_inf(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
    return (e == EXP_W'(EXP_SPECIAL)) && (m == '0);
  endfunction

  // Sign is ignored: both 0x00 and 0x80 mean zero.
  function automatic logic is_zero(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
    return (e == '0) && (m == '0);
  endfunction

endpackage

// File: rtl/fp8_to_fixed_conv.sv
// Converts one fp8 operand into a signed two's-complement fixed-point word with
// FRAC_BITS fractional bits, shifting the magnitude one bit per cycle.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_data/valid/ready   fp8 operand handshake; in_ready is high only in idle
//   out_data/valid/ready  fixed-point result handshake; result held until out_ready
//   out_nan, out_inf      result came from a NaN / an infinity (saturated) input
//
// Optional build macro FP8_CONV_ROUND_EN: right shifts keep guard and sticky bits
// and the magnitude is rounded to nearest, ties to even, before negation.
// Without it right shifts truncate toward zero.
module fp8_to_fixed_conv
  import fp8_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 6,
  parameter int unsigned OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_nan,
  output logic             out_inf
);

  localparam int unsigned CntW = $clog2(OUT_W) + 1;

  conv_state_e state_q, state_d;

  logic [OUT_W-1:0] mag_q, mag_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             sign_q, sign_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             nan_q, nan_d;
  logic             inf_q, inf_d;
`ifdef FP8_CONV_ROUND_EN
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
`endif

  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              in_nan, in_inf, in_zero, in_special;
  int                shift_amt;
  int                shift_abs;
  logic [OUT_W-1:0]  mag_fix;

  assign in_exp     = in_data[6:3];
  assign in_mant    = in_data[2:0];
  assign in_nan     = is_nan(in_exp, in_mant);
  assign in_inf     = is_inf(in_exp, in_mant);
  assign in_zero    = is_zero(in_exp, in_mant);
  assign in_special = in_nan | in_inf | in_zero;

  // {1,m} is the mantissa scaled by 2^MANT_W, so the net shift is e - bias - MANT_W + FRAC_BITS.
  always_comb begin
    shift_amt = int'({28'd0, in_exp}) - int'(FP8_BIAS + MANT_W) + int'(FRAC_BITS);
    shift_abs = (shift_amt < 0) ? -shift_amt : shift_amt;
  end

`ifdef FP8_CONV_ROUND_EN
  assign mag_fix = mag_q + OUT_W'(guard_q & (sticky_q | mag_q[0]));
`else
  assign mag_fix = mag_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic. SHIFT leaves on its last shift (cnt <= 1) so the final
  // shift and the move to FIX share one edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = in_special ? StDone : StShift;
      StShift: if (cnt_q <= CntW'(1)) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    sign_d      = sign_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    nan_d       = nan_q;
    inf_d       = inf_q;
`ifdef FP8_CONV_ROUND_EN
    guard_d     = guard_q;
    sticky_d    = sticky_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = in_data[7];
          nan_d  = in_nan;
          inf_d  = in_inf;
          mag_d  = OUT_W'({1'b1, in_mant});
          cnt_d  = CntW'(shift_abs);
          dir_d  = (shift_amt < 0);
`ifdef FP8_CONV_ROUND_EN
          guard_d  = 1'b0;
          sticky_d = 1'b0;
`endif
          if (in_nan || in_zero) begin
            out_data_d  = '0;
            out_valid_d = 1'b1;
          end else if (in_inf) begin
            // Symmetric saturation: +/-(2^(OUT_W-1)-1)
            out_data_d  = in_data[7] ? {1'b1, {(OUT_W-2){1'b0}}, 1'b1}
                                     : {1'b0, {(OUT_W-1){1'b1}}};
            out_valid_d = 1'b1;
          end
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
          if (dir_q) begin
            mag_d = mag_q >> 1;
`ifdef FP8_CONV_ROUND_EN
            guard_d  = mag_q[0];
            sticky_d = sticky_q | guard_q;
`endif
          end else begin
            mag_d = mag_q << 1;
          end
        end
      end
      StFix: begin
        out_data_d  = sign_q ? (OUT_W'(0) - mag_fix) : mag_fix;
        out_valid_d = 1'b1;
      end
      StDone: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag_q       <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      sign_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      nan_q       <= 1'b0;
      inf_q       <= 1'b0;
`ifdef FP8_CONV_ROUND_EN
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
`endif
    end else begin
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      sign_q      <= sign_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      nan_q       <= nan_d;
      inf_q       <= inf_d;
`ifdef FP8_CONV_ROUND_EN
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
`endif
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_data  = out_data_q;
    out_valid = out_valid_q;
    out_nan   = nan_q;
    out_inf   = inf_q;
  end

endmodule

// File: tb/tb_fp8_to_fixed_conv.sv
// Directed bench for fp8_to_fixed_conv with hand-computed expected results.
module tb_fp8_to_fixed_conv;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_nan;
  logic        out_inf;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FP8_CONV_ROUND_EN
  localparam logic [15:0] Exp0F = 16'h0002;
  localparam logic [15:0] Exp01 = 16'h0001;
`else
  localparam logic [15:0] Exp0F = 16'h0001;
  localparam logic [15:0] Exp01 = 16'h0000;
`endif

  fp8_to_fixed_conv #(
    .FRAC_BITS(6),
    .OUT_W    (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_nan  (out_nan),
    .out_inf  (out_inf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Present one operand, count edges (accept edge = 1) until out_valid, check
  // the result, then hand it off with out_ready.
  task automatic convert(input string tag, input logic [7:0] op, input logic [15:0] exp_d,
                         input logic exp_nan, input logic exp_inf, input int exp_lat);
    int edges;
    @(negedge clk);
    in_data  = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges    = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_lat"}, edges, exp_lat);
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, exp_d});
    check({tag, "_nan"}, {31'd0, out_nan}, {31'd0, exp_nan});
    check({tag, "_inf"}, {31'd0, out_inf}, {31'd0, exp_inf});
    check({tag, "_inrdy_busy"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_vld_clr"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_inrdy_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_nan", {31'd0, out_nan}, 32'd0);
    check("rst_inf", {31'd0, out_inf}, 32'd0);
    check("rst_inrdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal values: latency |s|+2 with s = e - 4
    convert("p1",    8'h38, 16'h0040, 1'b0, 1'b0, 5);
    convert("m1",    8'hB8, 16'hFFC0, 1'b0, 1'b0, 5);
    convert("p240",  8'h77, 16'h3C00, 1'b0, 1'b0, 12);
    convert("m240",  8'hF7, 16'hC400, 1'b0, 1'b0, 12);
    convert("p4",    8'h48, 16'h0100, 1'b0, 1'b0, 7);
    // Specials and zero: 1 edge
    convert("nan",   8'h7F, 16'h0000, 1'b1, 1'b0, 1);
    convert("pinf",  8'h78, 16'h7FFF, 1'b0, 1'b1, 1);
    convert("minf",  8'hF8, 16'h8001, 1'b0, 1'b1, 1);
    convert("pzero", 8'h00, 16'h0000, 1'b0, 1'b0, 1);
    convert("mzero", 8'h80, 16'h0000, 1'b0, 1'b0, 1);
    // Right shifts: 15>>3 and 9>>4
    convert("r0F",   8'h0F, Exp0F,    1'b0, 1'b0, 5);
    convert("r01",   8'h01, Exp01,    1'b0, 1'b0, 6);
    convert("rm0F",  8'h8F, 16'd0 - Exp0F, 1'b0, 1'b0, 5);

    // Backpressure: result held, in_valid ignored while in DONE
    @(negedge clk);
    in_data  = 8'h38;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_valid0", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_data  = 8'h77;
      in_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", {16'd0, out_data}, 32'h40);
      check("bp_inrdy", {31'd0, in_ready}, 32'd0);
    end
    // Release with in_valid still high: must not be accepted on the same edge
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_rel_valid", {31'd0, out_valid}, 32'd0);
    check("bp_rel_inrdy", {31'd0, in_ready}, 32'd1);
    check("bp_rel_data", {16'd0, out_data}, 32'h40);
    convert("bp_next", 8'hB8, 16'hFFC0, 1'b0, 1'b0, 5);

    // Reset during SHIFT of 0x77 discards the conversion
    @(negedge clk);
    in_data  = 8'h77;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mr_inrdy", {31'd0, in_ready}, 32'd1);
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("mr_no_output", {31'd0, out_valid}, 32'd0);
    convert("mr_after", 8'h38, 16'h0040, 1'b0, 1'b0, 5);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/fp8_to_fixed_conv.md
Name: fp8_to_fixed_conv

Overview:
- Downstream stage of the 8-bit minifloat adder.
- Accepts one registered adder result byte: sign[7], exponent[6:3] (bias 7), mantissa[2:0] (hidden 1).
- Converts it to a signed two's-complement fixed-point word using a one-bit-per-cycle shift FSM.
- Valid/ready handshakes on both sides let it sit between the adder output register and a host or serial readout.

Parameters:
- FRAC_BITS, 6: fractional bits of the output word.
- OUT_W, 16: output word width. Must satisfy OUT_W >= FRAC_BITS+10.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  8  fp8 operand (S|EEEE|MMM)
- in_valid  in  1  operand valid
- in_ready  out  1  high in IDLE only
- out_data  out  OUT_W  signed fixed-point result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_nan  out  1  result came from a NaN input
- out_inf  out  1  result came from ±inf (saturated)

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset values: state=IDLE; out_data=0; out_valid=0; out_nan=0; out_inf=0; in_ready=1 (combinational from IDLE).
- Reset mid-operation aborts the current conversion and discards it; no output is produced.
- Input classification (e=exp, m=mant):
  - NaN: e=15 and m!=0.
  - Inf: e=15 and m=0.
  - Zero: e=0 and m=0 (adder's zero encoding; sign ignored).
  - Otherwise normal, value 1.m × 2^(e-7). e=0 with m!=0 is normal; there are no denormals.
- Shift amount s = e - 10 + FRAC_BITS (signed). Range is -4..10 for default FRAC_BITS.
- FSM states: IDLE, SHIFT, FIX, DONE.
- IDLE:
  - On in_valid=1, capture the operand (handshake edge).
  - NaN: out_data=0, out_nan=1 -> DONE.
  - Inf: out_data = +(2^(OUT_W-1)-1) or -(2^(OUT_W-1)-1) by sign, out_inf=1 -> DONE.
  - Zero: out_data=0 -> DONE.
  - Normal: mag={1,m} zero-extended to OUT_W; cnt=|s|; dir=(s<0); flags cleared -> SHIFT.
- SHIFT:
  - If cnt!=0: mag shifts one bit (left if dir=0, logical right if dir=1) and cnt decrements.
  - If cnt==0: go to FIX.
  - Right shifts truncate the magnitude (round toward zero).
- FIX: out_data = sign ? -mag : mag -> DONE.
- DONE:
  - out_valid=1; out_data and flags are held stable.
  - On out_ready=1: out_valid clears on that edge -> IDLE.
  - in_valid is ignored outside IDLE; no new operand is accepted in the same cycle as out_ready.
- Latency, counted from the accepting edge to out_valid high:
  - Normal operand: |s|+2 edges.
  - Special or zero operand: 1 edge.
- Throughput: one conversion in flight; at least 1 cycle in IDLE between results.
- Width rules:
  - Left shift never overflows (max 15<<10 = 15360 < 2^15).
  - Negation is OUT_W-bit two's complement.
  - cnt width is clog2(OUT_W)+1.

Optional Feature:
- Macro: FP8_CONV_ROUND_EN.
- Defined: right shifts keep a guard bit and a sticky bit. In FIX the magnitude is rounded to nearest, ties to even, before negation.
- Undefined: truncation toward zero; no guard/sticky logic.

Decomposition:
- Shared package fp8_pkg holds:
  - field widths (EXP_W=4, MANT_W=3)
  - FP8_BIAS=7 and EXP_SPECIAL=15
  - the state encoding for IDLE/SHIFT/FIX/DONE
  - classification helper functions (is_nan, is_inf, is_zero)
- These are shared with the adder.
- No sub-module; the shifter, counter and FSM live in one module.

Test Plan:
- 0x38 (+1.0) -> out_data=0x0040, out_valid high 5 edges after accept; 0xB8 -> 0xFFC0.
- 0x77 (+240) -> 0x3C00 after 12 edges; 0xF7 -> 0xC400.
- 0x7F (NaN) -> out_data=0, out_nan=1, 1 edge. 0x78 -> 0x7FFF, out_inf=1. 0xF8 -> 0x8001, out_inf=1.
- 0x00 and 0x80 -> out_data=0, no flags. 0x0F -> 0x0001 (truncate), or 0x0002 with FP8_CONV_ROUND_EN. 0x01 -> 0x0000, or 0x0001 with the macro.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data/out_valid stable, in_ready=0, in_valid pulses ignored; release -> IDLE, next operand accepted.
- Assert rst_n=0 during SHIFT of 0x77 -> next edge IDLE, out_valid=0, out_data=0; following 0x38 converts correctly.
